// File: rtl/fd_circle_fetch.sv
// Raster-scan sequencer for the FAST-9 register file. For each candidate pixel it reads the centre
// pixel and its 16 radius-3 circle pixels from SRAM, then holds the loaded set until detAck.
module fd_circle_fetch #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int ADDR_W   = 12,
  parameter int SRAM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              sramRe,
  output logic [ADDR_W-1:0] sramAddr,
  output logic              regWe,
  output logic [4:0]        regAddr,
  output logic              readen,
  output logic [7:0]        pixX,
  output logic [7:0]        pixY,
  input  logic              detAck,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, EVAL, NEXT} state_t;

  state_t              state;
  logic [4:0]          k;
  logic [1:0]          drainCnt;
  logic [ADDR_W-1:0]   rowBase;
  logic                wePipe   [SRAM_LAT];
  logic [4:0]          addrPipe [SRAM_LAT];

  logic                lastX, lastY;
  logic [7:0]          nextX, nextY;
  logic [ADDR_W-1:0]   nextBase;
  logic [ADDR_W-1:0]   pixBase;

  // Circle offset dy*IMG_W+dx as a modulo-2**ADDR_W constant; negative offsets wrap and cancel on add.
  function automatic logic [ADDR_W-1:0] circle_off(input logic [4:0] idx);
    int dx, dy;
    dx = 0;
    dy = 0;
    case (idx)
      5'd1:  begin dx =  0; dy = -3; end
      5'd2:  begin dx =  1; dy = -3; end
      5'd3:  begin dx =  2; dy = -2; end
      5'd4:  begin dx =  3; dy = -1; end
      5'd5:  begin dx =  3; dy =  0; end
      5'd6:  begin dx =  3; dy =  1; end
      5'd7:  begin dx =  2; dy =  2; end
      5'd8:  begin dx =  1; dy =  3; end
      5'd9:  begin dx =  0; dy =  3; end
      5'd10: begin dx = -1; dy =  3; end
      5'd11: begin dx = -2; dy =  2; end
      5'd12: begin dx = -3; dy =  1; end
      5'd13: begin dx = -3; dy =  0; end
      5'd14: begin dx = -3; dy = -1; end
      5'd15: begin dx = -2; dy = -2; end
      5'd16: begin dx = -1; dy = -3; end
      default: begin dx = 0; dy = 0; end
    endcase
    return ADDR_W'(dy * IMG_W + dx);
  endfunction

  assign lastX   = (pixX == 8'(IMG_W - 4));
  assign lastY   = (pixY == 8'(IMG_H - 4));
  assign pixBase = rowBase + ADDR_W'(pixX);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nextX    = pixX + 8'd1;
    nextY    = pixY;
    nextBase = rowBase;
    if (lastX) begin
      nextX = 8'd3;
      if (lastY) begin
        nextY    = 8'd3;
        nextBase = ADDR_W'(3 * IMG_W);
      end else begin
        nextY    = pixY + 8'd1;
        nextBase = rowBase + ADDR_W'(IMG_W);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      drainCnt <= '0;
      rowBase  <= ADDR_W'(3 * IMG_W);
      pixX     <= 8'd3;
      pixY     <= 8'd3;
      sramRe   <= 1'b0;
      sramAddr <= '0;
      readen   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle itself is IDLE; a start there is dropped.
          if (start && !done) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            sramRe   <= 1'b1;
            k        <= 5'd0;
            sramAddr <= pixBase + circle_off(5'd0);
          end
        end
        ISSUE: begin
          if (k == 5'd16) begin
            sramRe   <= 1'b0;
            drainCnt <= 2'd0;
            state    <= DRAIN;
          end else begin
            k        <= k + 5'd1;
            sramAddr <= pixBase + circle_off(k + 5'd1);
          end
        end
        DRAIN: begin
          if (drainCnt == 2'(SRAM_LAT - 1)) begin
            readen <= 1'b1;
            state  <= EVAL;
          end else begin
            drainCnt <= drainCnt + 2'd1;
          end
        end
        EVAL: begin
          if (detAck) begin
            readen <= 1'b0;
            state  <= NEXT;
          end
        end
        NEXT: begin
          pixX    <= nextX;
          pixY    <= nextY;
          rowBase <= nextBase;
          if (lastX && lastY) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state    <= ISSUE;
            sramRe   <= 1'b1;
            k        <= 5'd0;
            sramAddr <= nextBase + ADDR_W'(nextX) + circle_off(5'd0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write strobe and slot trail the read strobe by SRAM_LAT; the slot only advances on a real write.
  // NOTE: the pipeline is a small register array, so it is reset; a reset mid-scan must not leak writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SRAM_LAT; i++) begin
        wePipe[i]   <= 1'b0;
        addrPipe[i] <= '0;
      end
    end else begin
      wePipe[0] <= sramRe;
      if (sramRe) addrPipe[0] <= k;
      for (int i = 1; i < SRAM_LAT; i++) begin
        wePipe[i] <= wePipe[i-1];
        if (wePipe[i-1]) addrPipe[i] <= addrPipe[i-1];
      end
    end
  end

  assign regWe   = wePipe[SRAM_LAT-1];
  assign regAddr = addrPipe[SRAM_LAT-1];

endmodule

// File: tb/tb_fd_circle_fetch.sv
// Self-checking bench for fd_circle_fetch: three instances (64x64/lat1, 8x8/lat1, 7x9/lat3) driven
// one at a time and compared cycle by cycle against a per-pixel model of the expected fetch sequence.
module tb_fd_circle_fetch;

  typedef struct packed {
    logic        re;
    logic [11:0] addr;
    logic        we;
    logic [4:0]  ra;
    logic        rd;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        busy;
    logic        done;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic detAck = 1'b0;
  int   sel = 0;

  always #5 clock = ~clock;

  logic        st_a, st_b, st_c, ack_a, ack_b, ack_c;
  logic        a_re, b_re, c_re, a_we, b_we, c_we, a_rd, b_rd, c_rd;
  logic        a_busy, b_busy, c_busy, a_done, b_done, c_done;
  logic [11:0] a_addr, b_addr, c_addr;
  logic [4:0]  a_ra, b_ra, c_ra;
  logic [7:0]  a_x, b_x, c_x, a_y, b_y, c_y;

  assign st_a  = start  && (sel == 0);
  assign st_b  = start  && (sel == 1);
  assign st_c  = start  && (sel == 2);
  assign ack_a = detAck && (sel == 0);
  assign ack_b = detAck && (sel == 1);
  assign ack_c = detAck && (sel == 2);

  fd_circle_fetch #(.IMG_W(64), .IMG_H(64), .ADDR_W(12), .SRAM_LAT(1)) dut_a (
    .clock(clock), .reset(reset), .start(st_a), .sramRe(a_re), .sramAddr(a_addr), .regWe(a_we),
    .regAddr(a_ra), .readen(a_rd), .pixX(a_x), .pixY(a_y), .detAck(ack_a), .busy(a_busy), .done(a_done));

  fd_circle_fetch #(.IMG_W(8), .IMG_H(8), .ADDR_W(12), .SRAM_LAT(1)) dut_b (
    .clock(clock), .reset(reset), .start(st_b), .sramRe(b_re), .sramAddr(b_addr), .regWe(b_we),
    .regAddr(b_ra), .readen(b_rd), .pixX(b_x), .pixY(b_y), .detAck(ack_b), .busy(b_busy), .done(b_done));

  fd_circle_fetch #(.IMG_W(7), .IMG_H(9), .ADDR_W(12), .SRAM_LAT(3)) dut_c (
    .clock(clock), .reset(reset), .start(st_c), .sramRe(c_re), .sramAddr(c_addr), .regWe(c_we),
    .regAddr(c_ra), .readen(c_rd), .pixX(c_x), .pixY(c_y), .detAck(ack_c), .busy(c_busy), .done(c_done));

  obs_t cur;
  always_comb begin
    case (sel)
      0:       cur = {a_re, a_addr, a_we, a_ra, a_rd, a_x, a_y, a_busy, a_done};
      1:       cur = {b_re, b_addr, b_we, b_ra, b_rd, b_x, b_y, b_busy, b_done};
      default: cur = {c_re, c_addr, c_we, c_ra, c_rd, c_x, c_y, c_busy, c_done};
    endcase
  end

  int checks = 0;
  int failures = 0;
  int cur_w, cur_h, cur_lat;
  int exp_ra;
  int ra_mem[3];
  int dxs[17] = '{0, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int dys[17] = '{0, -3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  function automatic obs_t mk(bit re, int addr, bit we, int ra, bit rd, int x, int y, bit bz, bit dn);
    obs_t o;
    o = {re, 12'(addr), we, 5'(ra), rd, 8'(x), 8'(y), bz, dn};
    return o;
  endfunction

  // Address is only meaningful with sramRe and pixel position only with readen, except at reset.
  function automatic obs_t msk(obs_t o, bit strict);
    if (!strict) begin
      if (!o.re) o.addr = '0;
      if (!o.rd) begin
        o.x = '0;
        o.y = '0;
      end
    end
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("re=%0b addr=%0d we=%0b ra=%0d rd=%0b x=%0d y=%0d busy=%0b done=%0b",
                     o.re, o.addr, o.we, o.ra, o.rd, o.x, o.y, o.busy, o.done);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic select(int s);
    ra_mem[sel] = exp_ra;
    sel    = s;
    exp_ra = ra_mem[s];
    case (s)
      0:       begin cur_w = 64; cur_h = 64; cur_lat = 1; end
      1:       begin cur_w = 8;  cur_h = 8;  cur_lat = 1; end
      default: begin cur_w = 7;  cur_h = 9;  cur_lat = 3; end
    endcase
    #1;
  endtask

  // Entered on the first ISSUE cycle of pixel (x,y); returns on the cycle after NEXT.
  task automatic run_pixel(string tag, int x, int y, int hold, bit noise);
    obs_t g, w;
    for (int c = 0; c <= 17 + cur_lat; c++) begin
      bit re, we;
      int kc;
      re = (c <= 16);
      we = (c >= cur_lat) && (c <= 16 + cur_lat);
      kc = re ? c : 0;
      if (we) exp_ra = c - cur_lat;
      w = mk(re, (y + dys[kc]) * cur_w + x + dxs[kc], we, exp_ra, c == 17 + cur_lat, x, y, 1, 0);
      g = msk(cur, 0);
      w = msk(w, 0);
      checks++;
      if (g !== w) begin
        failures++;
        $display("FAIL %s fetch (%0d,%0d) c=%0d: got %s, expected %s", tag, x, y, c, fmt(g), fmt(w));
      end
      if (c < 17 + cur_lat) begin
        if (noise) begin
          start  = 1'($urandom_range(0, 1));
          detAck = 1'($urandom_range(0, 1));
        end
        tick();
      end
    end
    detAck = 1'b0;
    start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    repeat (hold) begin
      tick();
      w = msk(mk(0, 0, 0, 16, 1, x, y, 1, 0), 0);
      g = msk(cur, 0);
      checks++;
      if (g !== w) begin
        failures++;
        $display("FAIL %s eval-hold (%0d,%0d): got %s, expected %s", tag, x, y, fmt(g), fmt(w));
      end
    end
    detAck = 1'b1;
    tick();
    detAck = 1'b0;
    start  = 1'b0;
    w = msk(mk(0, 0, 0, 16, 0, 0, 0, 1, 0), 0);
    g = msk(cur, 0);
    checks++;
    if (g !== w) begin
      failures++;
      $display("FAIL %s next (%0d,%0d): got %s, expected %s", tag, x, y, fmt(g), fmt(w));
    end
    tick();
  endtask

  task automatic test_reset();
    obs_t g, w;
    reset  = 1'b1;
    start  = 1'b0;
    detAck = 1'b0;
    exp_ra = 0;
    ra_mem = '{0, 0, 0};
    repeat (3) tick();
    reset = 1'b0;
    w = mk(0, 0, 0, 0, 0, 3, 3, 0, 0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      for (int s = 0; s < 3; s++) begin
        select(s);
        g = cur;
        checks++;
        if (g !== w) begin
          failures++;
          $display("FAIL reset dut%0d cyc=%0d: got %s, expected %s", s, cyc, fmt(g), fmt(w));
        end
      end
    end
  endtask

  task automatic test_first_pixels();
    select(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_pixel("first", 3, 3, 10, 0);
    run_pixel("second", 4, 3, int'($urandom_range(0, 3)), 1);
    run_pixel("third", 5, 3, int'($urandom_range(0, 3)), 1);
  endtask

  // Enters on the first ISSUE cycle of (6,3) and resets at k=8.
  task automatic test_reset_mid();
    obs_t g, w;
    repeat (8) tick();
    w = mk(1, 6 * 64 + 7, 1, 7, 0, 0, 0, 1, 0);
    g = msk(cur, 0);
    checks++;
    if (g !== msk(w, 0)) begin
      failures++;
      $display("FAIL mid-scan k=8: got %s, expected %s", fmt(g), fmt(msk(w, 0)));
    end
    reset = 1'b1;
    #1;
    w = mk(0, 0, 0, 0, 0, 3, 3, 0, 0);
    g = cur;
    checks++;
    if (g !== w) begin
      failures++;
      $display("FAIL async reset: got %s, expected %s", fmt(g), fmt(w));
    end
    exp_ra = 0;
    ra_mem = '{0, 0, 0};
    tick();
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_pixel("restart", 3, 3, 1, 1);
  endtask

  task automatic scan(string tag, int s, int idle);
    obs_t g, w;
    select(s);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int y = 3; y <= cur_h - 4; y++)
      for (int x = 3; x <= cur_w - 4; x++)
        run_pixel(tag, x, y, int'($urandom_range(0, 2)), 1);
    w = msk(mk(0, 0, 0, exp_ra, 0, 0, 0, 0, 1), 0);
    g = msk(cur, 0);
    checks++;
    if (g !== w) begin
      failures++;
      $display("FAIL %s done pulse: got %s, expected %s", tag, fmt(g), fmt(w));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < idle; i++) begin
      w = msk(mk(0, 0, 0, exp_ra, 0, 0, 0, 0, 0), 0);
      g = msk(cur, 0);
      checks++;
      if (g !== w) begin
        failures++;
        $display("FAIL %s idle after done i=%0d: got %s, expected %s", tag, i, fmt(g), fmt(w));
      end
      tick();
    end
  endtask

  task automatic test_small_scan();
    scan("scan8x8", 1, 5);
  endtask

  task automatic test_back_to_back();
    scan("b2b8x8", 1, 1);
    scan("b2b8x8_again", 1, 3);
  endtask

  task automatic test_lat3();
    scan("lat3", 2, 3);
  endtask

  initial begin
    test_reset();
    test_first_pixels();
    test_reset_mid();
    test_small_scan();
    test_back_to_back();
    test_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
